// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM of the multicycle MIPS core. Walks each instruction through
//   IF/ID/EXE/MEM/WB and drives the PC, IR, register-file, ALU and data-memory
//   controls for the datapath.
// Ports
//   CLK, RST            clock (rising edge) and asynchronous active-high reset
//   opcode, funct, zero IR fields and ALU zero flag
//   PCWre, IRWre        PC / IR load enables
//   PCSrc               00 PC+4, 01 branch target, 10 jump target
//   RegWre, RegDst      register write enable; 00 rt, 01 rd, 10 $31
//   WrRegDSrc           00 ALU result, 01 memory data, 10 PC+4
//   ALUSrcB, ExtSel     0 rt / 1 immediate; 0 zero-extend / 1 sign-extend
//   ALUOp               000 add, 001 sub, 010 and, 011 or, 100 slt
//   mRD, mWR            data-memory read / write strobes
//   state               current state (debug)
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int SW  = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [OPW-1:0] opcode,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic           PCWre,
  output logic           IRWre,
  output logic [1:0]     PCSrc,
  output logic           RegWre,
  output logic [1:0]     RegDst,
  output logic [1:0]     WrRegDSrc,
  output logic           ALUSrcB,
  output logic           ExtSel,
  output logic [2:0]     ALUOp,
  output logic           mRD,
  output logic           mWR,
  output logic [SW-1:0]  state
);

  typedef enum logic [SW-1:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_ORI  = 6'b001101;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE  = 6'b000101;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;
  localparam logic [OPW-1:0] OP_JAL  = 6'b000011;
  localparam logic [OPW-1:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  state_t state_q, state_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    PCSrc     = 2'b00;
    RegWre    = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 2'b00;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    ALUOp     = ALU_ADD;
    mRD       = 1'b0;
    mWR       = 1'b0;

    // ALU/extender selects are driven through EXE, MEM and WB so the ALU
    // result stays stable while memory and write-back consume it.
    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      case (opcode)
        OP_R: begin
          case (funct)
            6'b100010: ALUOp = ALU_SUB;
            6'b100100: ALUOp = ALU_AND;
            6'b100101: ALUOp = ALU_OR;
            6'b101010: ALUOp = ALU_SLT;
            default:   ALUOp = ALU_ADD;
          endcase
        end
        OP_ADDI, OP_LW, OP_SW: begin
          ALUOp   = ALU_ADD;
          ExtSel  = 1'b1;
          ALUSrcB = 1'b1;
        end
        OP_ORI: begin
          ALUOp   = ALU_OR;
          ALUSrcB = 1'b1;
        end
        OP_BEQ, OP_BNE: ALUOp = ALU_SUB;
        default: ;
      endcase
    end

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (opcode)
          OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXE;
          OP_J: begin
            PCWre   = 1'b1;
            PCSrc   = 2'b10;
            state_d = S_IF;
          end
          OP_JAL: begin
            PCWre     = 1'b1;
            PCSrc     = 2'b10;
            RegWre    = 1'b1;
            RegDst    = 2'b10;
            WrRegDSrc = 2'b10;
            state_d   = S_IF;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            // Unrecognised opcode retires as a NOP.
            PCWre   = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_EXE: begin
        case (opcode)
          OP_BEQ: begin
            PCWre   = 1'b1;
            PCSrc   = zero ? 2'b01 : 2'b00;
            state_d = S_IF;
          end
          OP_BNE: begin
            PCWre   = 1'b1;
            PCSrc   = zero ? 2'b00 : 2'b01;
            state_d = S_IF;
          end
          OP_LW, OP_SW:          state_d = S_MEM;
          OP_R, OP_ADDI, OP_ORI: state_d = S_WB;
          default:               state_d = S_IF;
        endcase
      end
      S_MEM: begin
        case (opcode)
          OP_LW: begin
            mRD     = 1'b1;
            state_d = S_WB;
          end
          OP_SW: begin
            mWR     = 1'b1;
            PCWre   = 1'b1;
            state_d = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_WB: begin
        case (opcode)
          OP_R: begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
            RegDst = 2'b01;
          end
          OP_ADDI, OP_ORI: begin
            RegWre = 1'b1;
            PCWre  = 1'b1;
          end
          OP_LW: begin
            RegWre    = 1'b1;
            PCWre     = 1'b1;
            WrRegDSrc = 2'b01;
          end
          default: ;
        endcase
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase

    // Reset must block every enable immediately, even mid-cycle.
    if (RST) begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      PCSrc     = 2'b00;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 2'b00;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      ALUOp     = ALU_ADD;
      mRD       = 1'b0;
      mWR       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed and randomized instruction sequences for multicycle_ctrl, checked
//   cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       PCWre, IRWre, RegWre, ALUSrcB, ExtSel, mRD, mWR;
  logic [1:0] PCSrc, RegDst, WrRegDSrc;
  logic [2:0] ALUOp, state;

  int tests = 0;
  int fails = 0;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .PCSrc(PCSrc), .RegWre(RegWre),
    .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcB(ALUSrcB),
    .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef enum int {C_R, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_BNE,
                    C_J, C_JAL, C_NOP, C_HALT} cls_t;

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b000000: return C_R;
      6'b001000: return C_ADDI;
      6'b001101: return C_ORI;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b000101: return C_BNE;
      6'b000010: return C_J;
      6'b000011: return C_JAL;
      6'b111111: return C_HALT;
      default:   return C_NOP;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting in IF (called at a falling edge) and checks
  // every cycle against the instruction's expected state path and controls.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z);
    cls_t  c;
    int    sts[$];
    int    n;
    bit    last, writes, taken;
    int    exp_src, exp_dst, exp_wsrc, exp_alu, exp_srcb, exp_ext;
    opcode = op; funct = fn; zero = z;
    c = classify(op);
    case (c)
      C_R, C_ADDI, C_ORI: sts = '{0, 1, 2, 4};
      C_LW:               sts = '{0, 1, 2, 3, 4};
      C_SW:               sts = '{0, 1, 2, 3};
      C_BEQ, C_BNE:       sts = '{0, 1, 2};
      default:            sts = '{0, 1};
    endcase
    n      = sts.size();
    writes = (c == C_R || c == C_ADDI || c == C_ORI || c == C_LW || c == C_JAL);
    taken  = (c == C_BEQ && z) || (c == C_BNE && !z);
    exp_src  = (c == C_J || c == C_JAL) ? 2 : (taken ? 1 : 0);
    exp_dst  = (c == C_R) ? 1 : (c == C_JAL ? 2 : 0);
    exp_wsrc = (c == C_LW) ? 1 : (c == C_JAL ? 2 : 0);
    exp_alu  = 0;
    if (c == C_R) begin
      case (fn)
        6'h22: exp_alu = 1;
        6'h24: exp_alu = 2;
        6'h25: exp_alu = 3;
        6'h2A: exp_alu = 4;
        default: exp_alu = 0;
      endcase
    end else if (c == C_ORI) exp_alu = 3;
    else if (c == C_BEQ || c == C_BNE) exp_alu = 1;
    exp_srcb = (c == C_ADDI || c == C_ORI || c == C_LW || c == C_SW) ? 1 : 0;
    exp_ext  = (c == C_ADDI || c == C_LW || c == C_SW) ? 1 : (c == C_ORI ? 0 : -1);

    for (int k = 0; k < n; k++) begin
      #1;
      last = (k == n - 1);
      check($sformatf("%s.c%0d.state", name, k), 32'(state), 32'(sts[k]));
      check($sformatf("%s.c%0d.IRWre", name, k), 32'(IRWre), 32'(k == 0));
      check($sformatf("%s.c%0d.PCWre", name, k), 32'(PCWre), 32'(last));
      if (last)
        check($sformatf("%s.c%0d.PCSrc", name, k), 32'(PCSrc), 32'(exp_src));
      check($sformatf("%s.c%0d.RegWre", name, k), 32'(RegWre), 32'(last && writes));
      if (last && writes) begin
        check($sformatf("%s.c%0d.RegDst", name, k), 32'(RegDst), 32'(exp_dst));
        check($sformatf("%s.c%0d.WrRegDSrc", name, k), 32'(WrRegDSrc), 32'(exp_wsrc));
      end
      check($sformatf("%s.c%0d.mRD", name, k), 32'(mRD), 32'(c == C_LW && sts[k] == 3));
      check($sformatf("%s.c%0d.mWR", name, k), 32'(mWR), 32'(c == C_SW && sts[k] == 3));
      if (sts[k] >= 2) begin
        check($sformatf("%s.c%0d.ALUOp", name, k), 32'(ALUOp), 32'(exp_alu));
        check($sformatf("%s.c%0d.ALUSrcB", name, k), 32'(ALUSrcB), 32'(exp_srcb));
        if (exp_ext >= 0)
          check($sformatf("%s.c%0d.ExtSel", name, k), 32'(ExtSel), 32'(exp_ext));
      end
      $display("[TB] %s cycle %0d state=%0d PCWre=%0b PCSrc=%0d", name, k, state, PCWre, PCSrc);
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  logic [5:0] r_op, r_fn;
  logic [5:0] rfuncts [5];

  initial begin
    rfuncts = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    RST = 1'b1; opcode = 6'b000000; funct = 6'h20; zero = 1'b0;
    @(negedge CLK); @(negedge CLK);
    #1;
    check("reset.state", 32'(state), 32'd0);
    check("reset.IRWre", 32'(IRWre), 32'd0);
    check("reset.PCWre", 32'(PCWre), 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Directed instruction set coverage.
    run_instr("add",  6'b000000, 6'h20, 1'b0);
    run_instr("lw",   6'b100011, 6'h00, 1'b0);
    run_instr("beq_t",6'b000100, 6'h00, 1'b1);
    run_instr("beq_n",6'b000100, 6'h00, 1'b0);
    run_instr("bne_t",6'b000101, 6'h00, 1'b0);
    run_instr("bne_n",6'b000101, 6'h00, 1'b1);
    run_instr("jal",  6'b000011, 6'h00, 1'b0);
    run_instr("j",    6'b000010, 6'h00, 1'b0);
    run_instr("sw",   6'b101011, 6'h00, 1'b0);
    run_instr("addi", 6'b001000, 6'h00, 1'b0);
    run_instr("ori",  6'b001101, 6'h00, 1'b0);
    run_instr("sub",  6'b000000, 6'h22, 1'b0);
    run_instr("and",  6'b000000, 6'h24, 1'b0);
    run_instr("or",   6'b000000, 6'h25, 1'b0);
    run_instr("slt",  6'b000000, 6'h2A, 1'b0);
    run_instr("rdef", 6'b000000, 6'h07, 1'b0);
    run_instr("nop",  6'b010101, 6'h00, 1'b0);

    // Randomized instruction stream (halt excluded).
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       r_op = 6'($urandom_range(0, 62));
        default: begin
          case ($urandom_range(0, 6))
            0: r_op = 6'b000000; 1: r_op = 6'b001000; 2: r_op = 6'b001101;
            3: r_op = 6'b100011; 4: r_op = 6'b101011; 5: r_op = 6'b000100;
            default: r_op = 6'b000101;
          endcase
        end
      endcase
      r_fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                         : rfuncts[$urandom_range(0, 4)];
      run_instr($sformatf("rnd%0d", i), r_op, r_fn, 1'($urandom_range(0, 1)));
    end

    // Reset asserted asynchronously during MEM of a store.
    opcode = 6'b101011; funct = 6'h00; zero = 1'b0;
    repeat (3) begin @(posedge CLK); @(negedge CLK); end
    #1;
    check("abort.pre.state", 32'(state), 32'd3);
    check("abort.pre.mWR", 32'(mWR), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("abort.mWR", 32'(mWR), 32'd0);
    check("abort.state", 32'(state), 32'd0);
    check("abort.PCWre", 32'(PCWre), 32'd0);
    @(negedge CLK);
    #1;
    check("abort.hold.state", 32'(state), 32'd0);
    check("abort.hold.PCWre", 32'(PCWre), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_instr("sw_after_abort", 6'b101011, 6'h00, 1'b0);

    // Halt holds with all enables low until reset.
    opcode = 6'b111111; funct = 6'h00;
    @(posedge CLK); @(negedge CLK);
    #1;
    check("halt.id.PCWre", 32'(PCWre), 32'd0);
    @(posedge CLK); @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("halt.c%0d.state", i), 32'(state), 32'd7);
      check($sformatf("halt.c%0d.en", i),
            32'({PCWre, IRWre, RegWre, mRD, mWR}), 32'd0);
      @(posedge CLK); @(negedge CLK);
    end
    #2 RST = 1'b1;
    #1;
    check("halt.rst.state", 32'(state), 32'd0);
    check("halt.rst.IRWre", 32'(IRWre), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("halt.after.state", 32'(state), 32'd0);
    check("halt.after.IRWre", 32'(IRWre), 32'd1);
    @(negedge CLK);
    // One cycle advanced to ID with halt still on the bus; feed a new
    // instruction from a fresh reset so run_instr starts in IF.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    run_instr("add_after_halt", 6'b000000, 6'h20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
